// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: integer log2, pipeline
// depth for a given vector size, and default element/tag types.
// Optional build macro: BITONIC_SORT_TAG_EN (carries source-position tags).
package bitonic_pkg;

  localparam int DEF_N     = 64;
  localparam int DEF_WIDTH = 32;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  // Number of compare-exchange columns for an N-element bitonic sorter.
  function automatic int num_stages(input int n);
    int lg;
    lg = clog2_f(n);
    return lg * (lg + 1) / 2;
  endfunction

  typedef logic [DEF_WIDTH-1:0]        elem_t;
  typedef logic [clog2_f(DEF_N)-1:0]   tag_t;

endpackage

// File: rtl/bitonic_cas_col.sv
// One registered compare-exchange column of the bitonic network.
// Pairs (i, i^J) with i^J > i; ascending when (i & K) == 0, else descending.
// Ties are never swapped; comparison is unsigned.
// Optional build macro: BITONIC_SORT_TAG_EN adds tag ports that follow swaps.
module bitonic_cas_col
  import bitonic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int K     = 2,
  parameter int J     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               valid,
  input  logic               dir,
  input  logic [N*WIDTH-1:0] data,
  output logic               valid_q,
  output logic               dir_q,
  output logic [N*WIDTH-1:0] data_q
`ifdef BITONIC_SORT_TAG_EN
  ,
  input  logic [N*clog2_f(N)-1:0] tag,
  output logic [N*clog2_f(N)-1:0] tag_q
`endif
);

  // True when the pair must be exchanged to reach the wanted order.
  function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             up);
    return up ? (a > b) : (a < b);
  endfunction

  logic [N-1:0]       swap;
  logic [N*WIDTH-1:0] data_nxt;

  // Decide per pair whether to exchange; the flag sits on the lower index.
  always_comb begin
    swap = '0;
    for (int i = 0; i < N; i++) begin
      if ((i ^ J) > i) begin
        swap[i] = out_of_order(data[i*WIDTH +: WIDTH],
                               data[(i ^ J)*WIDTH +: WIDTH],
                               (i & K) == 0);
      end
    end
  end

  // Apply the exchanges to the element vector.
  always_comb begin
    data_nxt = data;
    for (int i = 0; i < N; i++) begin
      if (((i ^ J) > i) && swap[i]) begin
        data_nxt[i*WIDTH +: WIDTH]       = data[(i ^ J)*WIDTH +: WIDTH];
        data_nxt[(i ^ J)*WIDTH +: WIDTH] = data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Valid bit: cleared by reset or flush, otherwise advances unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid;
    end
  end

  // Payload registers are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      dir_q  <= dir;
      data_q <= data_nxt;
    end
  end

`ifdef BITONIC_SORT_TAG_EN
  localparam int TW = clog2_f(N);

  logic [N*TW-1:0] tag_nxt;

  // Tags follow exactly the same exchanges as their elements.
  always_comb begin
    tag_nxt = tag;
    for (int i = 0; i < N; i++) begin
      if (((i ^ J) > i) && swap[i]) begin
        tag_nxt[i*TW +: TW]       = tag[(i ^ J)*TW +: TW];
        tag_nxt[(i ^ J)*TW +: TW] = tag[i*TW +: TW];
      end
    end
  end

  // Tag register column, held together with the data.
  always_ff @(posedge clk) begin
    if (en) begin
      tag_q <= tag_nxt;
    end
  end
`endif

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter: one N-element vector per cycle in, sorted
// vector out S cycles later, ascending (dir=0) or descending (dir=1).
// A single global stall (out_valid & ~out_ready) freezes every column.
// Optional build macro: BITONIC_SORT_TAG_EN adds out_idx with each element's
// original input position.
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int S     = num_stages(N),
  localparam int LG    = clog2_f(N),
  localparam int OCC_W = clog2_f(S + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_dir,
  input  logic [N*WIDTH-1:0] in_bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_bus,
  output logic [OCC_W-1:0]   occupancy
`ifdef BITONIC_SORT_TAG_EN
  ,
  output logic [N*LG-1:0]    out_idx
`endif
);

  logic               stall;
  logic               in_xfer;
  logic               out_xfer;
  logic               col_valid [0:S];
  logic               col_dir   [0:S];
  logic [N*WIDTH-1:0] col_data  [0:S];

  assign col_valid[0] = in_valid;
  assign col_dir[0]   = in_dir;
  assign col_data[0]  = in_bus;

  assign out_valid = col_valid[S];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef BITONIC_SORT_TAG_EN
  logic [N*LG-1:0] col_tag [0:S];
  logic [N*LG-1:0] tag_init;

  // Every element enters tagged with its own input slot number.
  always_comb begin
    tag_init = '0;
    for (int i = 0; i < N; i++) begin
      tag_init[i*LG +: LG] = LG'(i);
    end
  end

  assign col_tag[0] = tag_init;
`endif

  // Column index for stage k=2^p, distance j=2^(q-1): p*(p-1)/2 + (p-q).
  for (genvar p = 1; p <= LG; p++) begin : g_k
    for (genvar q = p; q >= 1; q--) begin : g_j
      localparam int C = p * (p - 1) / 2 + (p - q);

      bitonic_cas_col #(
        .N     (N),
        .WIDTH (WIDTH),
        .K     (1 << p),
        .J     (1 << (q - 1))
      ) u_col (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stall),
        .clr     (flush),
        .valid   (col_valid[C]),
        .dir     (col_dir[C]),
        .data    (col_data[C]),
        .valid_q (col_valid[C+1]),
        .dir_q   (col_dir[C+1]),
        .data_q  (col_data[C+1])
`ifdef BITONIC_SORT_TAG_EN
        ,
        .tag     (col_tag[C]),
        .tag_q   (col_tag[C+1])
`endif
      );
    end
  end

  // Output ordering: reverse the ascending result for descending vectors;
  // the bus reads zero whenever no vector is presented.
  always_comb begin
    out_bus = '0;
    if (out_valid) begin
      for (int i = 0; i < N; i++) begin
        out_bus[i*WIDTH +: WIDTH] = col_dir[S] ? col_data[S][(N-1-i)*WIDTH +: WIDTH]
                                               : col_data[S][i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef BITONIC_SORT_TAG_EN
  // Source positions follow the same output reversal as the elements.
  always_comb begin
    out_idx = '0;
    if (out_valid) begin
      for (int i = 0; i < N; i++) begin
        out_idx[i*LG +: LG] = col_dir[S] ? col_tag[S][(N-1-i)*LG +: LG]
                                         : col_tag[S][i*LG +: LG];
      end
    end
  end
`endif

  // Occupancy tracks vectors in flight: +1 per input, -1 per output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Testbench for bitonic_sort_pipe at N=8, WIDTH=8 (six pipeline columns).
// Reference: a plain sort of each accepted vector, queued with its age.
module tb_bitonic_sort_pipe;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int S  = 6;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_dir;
  logic [BW-1:0] in_bus;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bus;
  logic [2:0]    occupancy;
`ifdef BITONIC_SORT_TAG_EN
  logic [N*3-1:0] out_idx;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [BW-1:0] data;
    int            pos;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  bitonic_sort_pipe #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_bus    (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .occupancy (occupancy)
`ifdef BITONIC_SORT_TAG_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  // Plain bubble sort, then optional reversal for descending order.
  function automatic logic [BW-1:0] sort_ref(input logic [BW-1:0] v, input logic d);
    int a[N];
    int t;
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) a[i] = int'(v[i*W +: W]);
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N - 1 - x; y++)
        if (a[y] > a[y+1]) begin
          t = a[y]; a[y] = a[y+1]; a[y+1] = t;
        end
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(d ? a[N-1-i] : a[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle against the model, then advance model and clock.
  task automatic cycle();
    logic mv;
    logic st;
    @(negedge clk);
    if (!rst_n) q.delete();
    mv = (q.size() > 0) && (q[0].pos == S - 1);
    st = mv && !out_ready;
    chk("out_valid", BW'(out_valid), BW'(mv));
    chk("in_ready", BW'(in_ready), BW'(!st));
    chk("occupancy", BW'(occupancy), BW'(q.size()));
    if (mv) chk("out_bus", out_bus, q[0].data);
    if (!rst_n) chk("reset_out_bus", out_bus, '0);
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else if (!st) begin
        if (mv) void'(q.pop_front());
        foreach (q[k]) q[k].pos++;
        if (in_valid) q.push_back('{sort_ref(in_bus, in_dir), 0});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(input int maxv);
    for (int i = 0; i < N; i++) in_bus[i*W +: W] = W'($urandom_range(0, maxv));
  endtask

  initial begin
    logic [BW-1:0] held;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dir = 1'b0;
    in_bus = '0; out_ready = 1'b1;

    // Reset state
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Single ascending vector, latency S
    in_bus = 64'h04_02_06_01_05_00_03_07; in_valid = 1'b1; in_dir = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (S - 1) cycle();
    chk("asc_valid_at_latency", BW'(out_valid), BW'(1));
    chk("asc_sorted", out_bus, 64'h07_06_05_04_03_02_01_00);
    chk("asc_occupancy", BW'(occupancy), BW'(1));
    repeat (2) cycle();

    // Same vector descending
    in_bus = 64'h04_02_06_01_05_00_03_07; in_valid = 1'b1; in_dir = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (S - 1) cycle();
    chk("desc_sorted", out_bus, 64'h00_01_02_03_04_05_06_07);
    repeat (2) cycle();

    // Back-to-back stream
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_vec(255); in_dir = 1'(c % 3 == 0);
      cycle();
    end
    chk("b2b_occupancy", BW'(occupancy), BW'(S));
    chk("b2b_in_ready", BW'(in_ready), BW'(1));

    // Full-pipe stall, then drain
    out_ready = 1'b0;
    held = out_bus;
    for (int c = 0; c < 10; c++) begin
      rand_vec(255);
      cycle();
    end
    chk("stall_hold_bus", out_bus, held);
    chk("stall_in_ready", BW'(in_ready), BW'(0));
    chk("stall_occupancy", BW'(occupancy), BW'(S));
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (S + 2) cycle();

    // Flush with four vectors in flight and a concurrent input
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_vec(255); in_dir = 1'(c & 1);
      cycle();
    end
    flush = 1'b1; in_bus = 64'hAA_AA_AA_AA_AA_AA_AA_AA;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", BW'(out_valid), BW'(0));
    chk("flush_occupancy", BW'(occupancy), BW'(0));
    repeat (S + 2) cycle();

    // Duplicates and all-equal vectors
    in_valid = 1'b1; in_dir = 1'b0; in_bus = 64'hFF_FF_00_00_05_05_05_05;
    cycle();
    in_dir = 1'b1; in_bus = 64'h2A_2A_2A_2A_2A_2A_2A_2A;
    cycle();
    in_valid = 1'b0;
    repeat (S - 2) cycle();
    chk("dup_sorted", out_bus, 64'hFF_FF_05_05_05_05_00_00);
    cycle();
    chk("equal_sorted", out_bus, 64'h2A_2A_2A_2A_2A_2A_2A_2A);
    cycle();

    // Random traffic with an asynchronous reset pulse mid-stream
    for (int c = 0; c < 150; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_dir    = 1'($urandom_range(0, 1));
      rand_vec(($urandom_range(0, 1) != 0) ? 3 : 255);
      if (c == 60) rst_n = 1'b0;
      if (c == 62) rst_n = 1'b1;
      cycle();
      if (c == 62) chk("post_reset_occupancy", BW'(occupancy), BW'(q.size()));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 2) cycle();
    chk("final_occupancy", BW'(occupancy), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
